// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, register/word types and the issue record
package cpu_pkg;
  localparam int NREGS = 16;
  localparam int AWIDTH = 4;
  localparam int DWIDTH = 16;
  typedef logic [AWIDTH-1:0] reg_addr_t;
  typedef logic [DWIDTH-1:0] word_t;
  typedef struct packed {
    reg_addr_t rd;
    logic rd_wr;
    word_t op1;
    word_t op2;
  } issue_t;
endpackage

// File: rtl/scoreboard.sv
// scoreboard: per-register busy bits, cleared by writeback and set by issue
// Ports: clk, reset (async active-low), clr (writeback one-hot), set (issue one-hot), busy (state).
module scoreboard
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [NREGS-1:0] clr,
  input  logic [NREGS-1:0] set,
  output logic [NREGS-1:0] busy
);
  logic [NREGS-1:0] busy_q, busy_d;
  // set is applied after clr so a new issue to rd survives the old writeback of rd
  assign busy_d = (busy_q & ~clr) | set;
  assign busy = busy_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) busy_q <= '0;
    else busy_q <= busy_d;
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: issue stage reading the regfile, bypassing writeback and blocking hazards
// Ports: clk, reset (async active-low); in_* decoded instruction (valid/ready);
// readAddr*/readData* regfile read ports; wb_* writeback observe; out_* one-entry
// output register (valid/ready); busy scoreboard; stall_count saturating stall counter.
module operand_fetch
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AWIDTH-1:0] in_rs1,
  input  logic [AWIDTH-1:0] in_rs2,
  input  logic [AWIDTH-1:0] in_rd,
  input  logic              in_rd_wr,
  output logic [AWIDTH-1:0] readAddr1,
  output logic [AWIDTH-1:0] readAddr2,
  input  logic [DWIDTH-1:0] readData1,
  input  logic [DWIDTH-1:0] readData2,
  input  logic              wb_valid,
  input  logic [AWIDTH-1:0] wb_addr,
  input  logic [DWIDTH-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_op1,
  output logic [DWIDTH-1:0] out_op2,
  output logic [AWIDTH-1:0] out_rd,
  output logic              out_rd_wr,
  output logic [NREGS-1:0]  busy,
  output logic [15:0]       stall_count
);
  logic [NREGS-1:0] clr, set;
  logic hazard, fire;
  issue_t out_q, out_d;
  logic out_valid_q;
  logic [15:0] stall_q;
  assign readAddr1 = in_rs1;
  assign readAddr2 = in_rs2;
  // a register written back this cycle already counts as free; regfile commits only at the edge,
  // so its value is taken from wb_data instead of readData
  always_comb begin
    clr = wb_valid ? NREGS'(1) << wb_addr : '0;
    hazard = (busy[in_rs1] & ~clr[in_rs1]) | (busy[in_rs2] & ~clr[in_rs2]) |
             (in_rd_wr & busy[in_rd] & ~clr[in_rd]);
    in_ready = (~out_valid_q | out_ready) & ~hazard;
    fire = in_valid & in_ready;
    set = (fire & in_rd_wr) ? NREGS'(1) << in_rd : '0;
    out_d.rd = in_rd;
    out_d.rd_wr = in_rd_wr;
    out_d.op1 = (wb_valid && wb_addr == in_rs1) ? wb_data : readData1;
    out_d.op2 = (wb_valid && wb_addr == in_rs2) ? wb_data : readData2;
  end
  scoreboard u_sb (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .set  (set),
    .busy (busy)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_q <= '0;
      stall_q <= '0;
    end else begin
      if (fire) begin
        out_valid_q <= 1'b1;
        out_q <= out_d;
      end else if (out_ready) out_valid_q <= 1'b0;
      if (in_valid && !in_ready && !(&stall_q)) stall_q <= stall_q + 16'd1;
    end
  assign out_valid = out_valid_q;
  assign out_op1 = out_q.op1;
  assign out_op2 = out_q.op2;
  assign out_rd = out_q.rd;
  assign out_rd_wr = out_q.rd_wr;
  assign stall_count = stall_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: randomized and directed checks of operand_fetch against a cycle model
module tb_operand_fetch;
  logic clk = 0, reset;
  logic in_valid, in_ready, in_rd_wr, wb_valid, out_valid, out_ready, out_rd_wr;
  logic [3:0] in_rs1, in_rs2, in_rd, readAddr1, readAddr2, wb_addr, out_rd;
  logic [15:0] readData1, readData2, wb_data, out_op1, out_op2, busy, stall_count;
  logic [15:0] rf[16];
  logic [15:0] mb, mop1, mop2, mstall;
  logic mvalid, mrdwr;
  logic [3:0] mrd;
  int pass = 0, total = 0;
  always #5 clk = ~clk;
  assign readData1 = rf[readAddr1];
  assign readData2 = rf[readAddr2];
  operand_fetch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wr(in_rd_wr),
    .readAddr1(readAddr1), .readAddr2(readAddr2), .readData1(readData1), .readData2(readData2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
    .out_rd(out_rd), .out_rd_wr(out_rd_wr), .busy(busy), .stall_count(stall_count)
  );
  function automatic bit exp_ready();
    logic [15:0] eff;
    eff = mb;
    if (wb_valid) eff[wb_addr] = 1'b0;
    return (!mvalid || out_ready) && !eff[in_rs1] && !eff[in_rs2] && !(in_rd_wr && eff[in_rd]);
  endfunction
  task automatic model_reset();
    mb = 0; mvalid = 0; mop1 = 0; mop2 = 0; mrd = 0; mrdwr = 0; mstall = 0;
  endtask
  task automatic idle();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_wr = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
  endtask
  task automatic tick();
    bit r, f;
    logic [15:0] o1, o2;
    r = exp_ready();
    f = in_valid && r;
    o1 = (wb_valid && wb_addr == in_rs1) ? wb_data : rf[in_rs1];
    o2 = (wb_valid && wb_addr == in_rs2) ? wb_data : rf[in_rs2];
    if (in_valid && !r && mstall != 16'hFFFF) mstall = mstall + 1;
    @(posedge clk);
    #1;
    if (wb_valid) begin rf[wb_addr] = wb_data; mb[wb_addr] = 1'b0; end
    if (f && in_rd_wr) mb[in_rd] = 1'b1;
    if (f) begin
      mvalid = 1; mop1 = o1; mop2 = o2; mrd = in_rd; mrdwr = in_rd_wr;
    end else if (out_ready) mvalid = 0;
  endtask
  task automatic issue(input logic [3:0] rs1, rs2, rd, input logic wr);
    in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_wr = wr;
  endtask
  task automatic drain();
    idle();
    for (int i = 0; i < 16; i++) begin
      wb_valid = 1; wb_addr = i[3:0]; wb_data = rf[i];
      tick();
    end
    idle();
    tick();
  endtask
  task automatic test_reset();
    idle();
    reset = 0;
    for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0h want 0", out_valid); else pass++;
    total++; if (busy !== 16'h0) $display("FAIL reset_busy got %0h want 0", busy); else pass++;
    total++; if ({out_op1, out_op2, out_rd, out_rd_wr} !== 37'h0) $display("FAIL reset_fields got %0h/%0h/%0h/%0h want 0", out_op1, out_op2, out_rd, out_rd_wr); else pass++;
    total++; if (stall_count !== 16'h0) $display("FAIL reset_stall got %0h want 0", stall_count); else pass++;
    reset = 1;
  endtask
  task automatic test_reset_mid();
    idle();
    issue(4'd1, 4'd1, 4'd3, 1'b1);
    tick();
    idle();
    in_valid = 1; in_rs1 = 4'd3;
    #1;
    total++; if (busy[3] !== 1'b1 || out_valid !== 1'b1) $display("FAIL midreset_pre busy=%0h out_valid=%0b want busy[3]=1 out_valid=1", busy, out_valid); else pass++;
    tick();
    #1;
    reset = 0;
    #1;
    total++; if (busy !== 16'h0 || out_valid !== 1'b0) $display("FAIL midreset_async busy=%0h out_valid=%0b want 0/0", busy, out_valid); else pass++;
    total++; if (stall_count !== 16'h0) $display("FAIL midreset_stall got %0h want 0", stall_count); else pass++;
    reset = 1;
    model_reset();
    idle();
    tick();
  endtask
  task automatic test_bypass();
    rf[5] = 16'h1111;
    issue(4'd5, 4'd6, 4'd8, 1'b0);
    wb_valid = 1; wb_addr = 4'd5; wb_data = 16'hBEEF;
    #1;
    total++; if (readAddr1 !== 4'd5 || readAddr2 !== 4'd6) $display("FAIL bypass_addr got %0h/%0h want 5/6", readAddr1, readAddr2); else pass++;
    total++; if (in_ready !== 1'b1) $display("FAIL bypass_ready got %0b want 1", in_ready); else pass++;
    tick();
    total++; if (out_op1 !== 16'hBEEF || out_op2 !== rf[6]) $display("FAIL bypass_ops got %0h/%0h want beef/%0h", out_op1, out_op2, rf[6]); else pass++;
    total++; if (busy[5] !== 1'b0) $display("FAIL bypass_busy5 got %0b want 0", busy[5]); else pass++;
    idle();
    tick();
  endtask
  task automatic test_raw_stall();
    issue(4'd0, 4'd0, 4'd2, 1'b1);
    tick();
    issue(4'd2, 4'd0, 4'd9, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL raw_stall_c%0d in_ready got %0b want 0", c, in_ready); else pass++;
      tick();
    end
    total++; if (stall_count !== 16'd3) $display("FAIL raw_stall_count got %0d want 3", stall_count); else pass++;
    wb_valid = 1; wb_addr = 4'd2; wb_data = 16'h00A5;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL raw_release in_ready got %0b want 1", in_ready); else pass++;
    tick();
    total++; if (out_op1 !== 16'h00A5 || out_valid !== 1'b1) $display("FAIL raw_op1 got %0h v=%0b want a5 v=1", out_op1, out_valid); else pass++;
    idle();
    tick();
  endtask
  task automatic test_collision();
    issue(4'd1, 4'd1, 4'd7, 1'b1);
    tick();
    issue(4'd4, 4'd4, 4'd7, 1'b1);
    wb_valid = 1; wb_addr = 4'd7; wb_data = 16'h7777;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL collide_ready got %0b want 1", in_ready); else pass++;
    tick();
    total++; if (busy[7] !== 1'b1 || busy !== mb) $display("FAIL collide_busy got %0h want %0h", busy, mb); else pass++;
    drain();
  endtask
  task automatic test_backpressure();
    rf[10] = 16'h0042;
    issue(4'd10, 4'd11, 4'd12, 1'b0);
    tick();
    out_ready = 0;
    issue(4'd3, 4'd4, 4'd13, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_c%0d got %0b want 0", c, in_ready); else pass++;
      tick();
      total++; if (out_valid !== 1'b1 || out_op1 !== 16'h0042 || out_rd !== 4'd12) $display("FAIL bp_hold_c%0d got v=%0b op1=%0h rd=%0h want 1/42/c", c, out_valid, out_op1, out_rd); else pass++;
    end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_release got %0b want 1", in_ready); else pass++;
    tick();
    total++; if (out_op1 !== rf[3] || out_op2 !== rf[4] || out_rd !== 4'd13 || out_rd_wr !== 1'b1) $display("FAIL bp_next got %0h/%0h/%0h/%0b want %0h/%0h/d/1", out_op1, out_op2, out_rd, out_rd_wr, rf[3], rf[4]); else pass++;
    drain();
  endtask
  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom); in_rs1 = 4'($urandom); in_rs2 = 4'($urandom);
      in_rd = 4'($urandom); in_rd_wr = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
      wb_valid = 1'($urandom); wb_addr = 4'($urandom); wb_data = 16'($urandom);
      if (mb != 0 && $urandom % 2 == 0) begin
        for (int k = 0; k < 16; k++) if (mb[k]) wb_addr = k[3:0];
      end
      #1;
      total++; if (in_ready !== exp_ready()) begin bad++; $display("FAIL rand_ready_c%0d got %0b want %0b", c, in_ready, exp_ready()); end else pass++;
      tick();
      total++;
      if ({out_valid, busy, stall_count} !== {mvalid, mb, mstall} ||
          (mvalid && {out_op1, out_op2, out_rd, out_rd_wr} !== {mop1, mop2, mrd, mrdwr})) begin
        bad++;
        $display("FAIL rand_state_c%0d got v=%0b b=%0h s=%0h %0h/%0h/%0h/%0b want v=%0b b=%0h s=%0h %0h/%0h/%0h/%0b",
                 c, out_valid, busy, stall_count, out_op1, out_op2, out_rd, out_rd_wr,
                 mvalid, mb, mstall, mop1, mop2, mrd, mrdwr);
      end else pass++;
      if (bad > 10) break;
    end
    drain();
  endtask
  task automatic test_saturation();
    issue(4'd0, 4'd0, 4'd1, 1'b1);
    tick();
    issue(4'd1, 4'd1, 4'd2, 1'b0);
    for (int c = 0; c < 65540; c++) tick();
    total++; if (stall_count !== 16'hFFFF || mstall !== 16'hFFFF) $display("FAIL sat_count got %0h want ffff", stall_count); else pass++;
    tick();
    total++; if (stall_count !== 16'hFFFF) $display("FAIL sat_nowrap got %0h want ffff", stall_count); else pass++;
    drain();
  endtask
  initial begin
    test_reset();
    test_reset_mid();
    test_bypass();
    test_raw_stall();
    test_collision();
    test_backpressure();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
